// File: rtl/reg_bus_bridge.sv
// UART-to-register-bus bridge: decodes 0x02 (write) / 0x01 (read) byte packets,
// drives a simple register port and returns an ack byte or the 4-byte read word.
module reg_bus_bridge #(
  parameter int TIMEOUT = 1000
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output logic [7:0]  opTxData,
  output logic        opTxValid,
  input  logic        ipTxReady,
  output logic [7:0]  opAddress,
  output logic [31:0] opWrData,
  output logic        opWrEnable,
  input  logic [31:0] ipRdData,
  output logic [7:0]  opErrCount
);

  // Tx handshake: a byte moves when opTxValid && ipTxReady at a rising edge;
  // once raised, opTxValid and opTxData hold until that transfer happens.

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_ADDR,
    S_WR_DATA,
    S_WR_STROBE,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t        state_q;
  logic          is_write_q;
  logic [1:0]    byte_idx_q;
  logic [1:0]    tx_last_q;
  logic          rd_cnt_q;
  logic [31:0]   shift_q;
  logic [CW-1:0] tmo_cnt_q;
  logic [7:0]    addr_q;
  logic [31:0]   wr_data_q;
  logic          wr_en_q;
  logic [7:0]    tx_data_q;
  logic          tx_valid_q;
  logic [7:0]    err_cnt_q;
  logic [7:0]    err_cnt_d;

  logic          in_rx_window;
  logic          tmo_hit;
  logic          err_event;

  always_comb begin
    in_rx_window = (state_q == S_CMD_ADDR) || (state_q == S_WR_DATA);
    tmo_hit      = in_rx_window && !ipRxValid && (tmo_cnt_q == TMO_LAST);
    err_event    = 1'b0;
    if (ipRxValid) begin
      case (state_q)
        S_IDLE:      err_event = (ipRxData != CMD_READ) && (ipRxData != CMD_WRITE);
        S_WR_STROBE,
        S_RD_WAIT,
        S_TX_SEND:   err_event = 1'b1;
        default:     err_event = 1'b0;
      endcase
    end
    // Any combination of sources in one cycle is a single increment.
    if (tmo_hit) begin
      err_event = 1'b1;
    end
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q    <= S_IDLE;
      is_write_q <= 1'b0;
      byte_idx_q <= 2'd0;
      tx_last_q  <= 2'd0;
      rd_cnt_q   <= 1'b0;
      shift_q    <= 32'd0;
      tmo_cnt_q  <= '0;
      addr_q     <= 8'd0;
      wr_data_q  <= 32'd0;
      wr_en_q    <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      wr_en_q   <= 1'b0;
      err_cnt_q <= err_cnt_d;
      case (state_q)
        S_IDLE: begin
          if (ipRxValid && ((ipRxData == CMD_READ) || (ipRxData == CMD_WRITE))) begin
            is_write_q <= (ipRxData == CMD_WRITE);
            tmo_cnt_q  <= '0;
            state_q    <= S_CMD_ADDR;
          end
        end
        S_CMD_ADDR: begin
          if (ipRxValid) begin
            addr_q    <= ipRxData;
            tmo_cnt_q <= '0;
            if (is_write_q) begin
              byte_idx_q <= 2'd0;
              state_q    <= S_WR_DATA;
            end else begin
              rd_cnt_q <= 1'b0;
              state_q  <= S_RD_WAIT;
            end
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        S_WR_DATA: begin
          if (ipRxValid) begin
            wr_data_q[{byte_idx_q, 3'b000} +: 8] <= ipRxData;
            tmo_cnt_q <= '0;
            if (byte_idx_q == 2'd3) begin
              wr_en_q <= 1'b1;
              state_q <= S_WR_STROBE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end else if (tmo_hit) begin
            state_q <= S_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        S_WR_STROBE: begin
          tx_data_q  <= ACK_BYTE;
          tx_valid_q <= 1'b1;
          byte_idx_q <= 2'd0;
          tx_last_q  <= 2'd0;
          state_q    <= S_TX_SEND;
        end
        S_RD_WAIT: begin
          // Second cycle: the register block has had a full cycle to settle.
          if (rd_cnt_q) begin
            shift_q    <= ipRdData;
            tx_data_q  <= ipRdData[7:0];
            tx_valid_q <= 1'b1;
            byte_idx_q <= 2'd0;
            tx_last_q  <= 2'd3;
            state_q    <= S_TX_SEND;
          end else begin
            rd_cnt_q <= 1'b1;
          end
        end
        S_TX_SEND: begin
          if (tx_valid_q && ipTxReady) begin
            if (byte_idx_q == tx_last_q) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              tx_data_q  <= shift_q[15:8];
              shift_q    <= {8'd0, shift_q[31:8]};
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign opTxData   = tx_data_q;
  assign opTxValid  = tx_valid_q;
  assign opAddress  = addr_q;
  assign opWrData   = wr_data_q;
  assign opWrEnable = wr_en_q;
  assign opErrCount = err_cnt_q;

endmodule

// File: tb/tb_reg_bus_bridge.sv
// Directed bench for reg_bus_bridge: write, read, backpressure, timeout,
// error counting/saturation and reset abort, with a one-cycle-latency register mock.
module tb_reg_bus_bridge;

  localparam int TMO = 20;

  logic        ipClk;
  logic        ipReset;
  logic [7:0]  ipRxData;
  logic        ipRxValid;
  logic [7:0]  opTxData;
  logic        opTxValid;
  logic        ipTxReady;
  logic [7:0]  opAddress;
  logic [31:0] opWrData;
  logic        opWrEnable;
  logic [31:0] ipRdData;
  logic [7:0]  opErrCount;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int tx_cyc = 0;
  int tx_before;

  reg_bus_bridge #(.TIMEOUT(TMO)) dut (
    .ipClk      (ipClk),
    .ipReset    (ipReset),
    .ipRxData   (ipRxData),
    .ipRxValid  (ipRxValid),
    .opTxData   (opTxData),
    .opTxValid  (opTxValid),
    .ipTxReady  (ipTxReady),
    .opAddress  (opAddress),
    .opWrData   (opWrData),
    .opWrEnable (opWrEnable),
    .ipRdData   (ipRdData),
    .opErrCount (opErrCount)
  );

  // clock / reset-independent infrastructure
  initial ipClk = 1'b0;
  always #5 ipClk = ~ipClk;

  // register block mock: data for the address seen at the previous edge
  initial ipRdData = 32'd0;
  always @(posedge ipClk)
    ipRdData <= (opAddress == 8'h03) ? 32'hDEADBEEF : {24'hC0FFEE, opAddress};

  always @(negedge ipClk) begin
    if (opWrEnable) wr_cnt++;
    if (opTxValid) tx_cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    ipRxData  = b;
    ipRxValid = 1'b1;
    @(negedge ipClk);
    ipRxValid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge ipClk);
  endtask

  // Receive n bytes LSB first from word; stall ready for stall_len cycles at byte stall_at.
  task automatic check_tx(input int n, input logic [31:0] word, input int stall_at,
                          input int stall_len, input string tag);
    int got;
    int stall;
    int budget;
    got = 0; stall = 0; budget = 0;
    while (got < n && budget < 100) begin
      if (opTxValid) begin
        chk({tag, "_data"}, {24'd0, opTxData}, {24'd0, word[8*got +: 8]});
        if (got == stall_at && stall < stall_len) begin
          ipTxReady = 1'b0;
          stall++;
        end else begin
          ipTxReady = 1'b1;
          got++;
        end
      end else begin
        ipTxReady = 1'b1;
      end
      @(negedge ipClk);
      budget++;
    end
    ipTxReady = 1'b1;
    chk({tag, "_count"}, got, n);
    chk({tag, "_end"}, {31'd0, opTxValid}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_txv"},  {31'd0, opTxValid},  32'd0);
    chk({tag, "_txd"},  {24'd0, opTxData},   32'd0);
    chk({tag, "_wen"},  {31'd0, opWrEnable}, 32'd0);
    chk({tag, "_addr"}, {24'd0, opAddress},  32'd0);
    chk({tag, "_wdat"}, opWrData,            32'd0);
    chk({tag, "_err"},  {24'd0, opErrCount}, 32'd0);
  endtask

  initial begin
    ipReset   = 1'b1;
    ipRxData  = 8'h00;
    ipRxValid = 1'b0;
    ipTxReady = 1'b1;

    // reset, with a bad rx strobe during reset that must be ignored
    wait_cyc(2);
    send_byte(8'h7F);
    chk_reset_vals("rst");
    ipReset = 1'b0;
    wait_cyc(1);
    chk("rst_rx_ignored", {24'd0, opErrCount}, 32'd0);

    // write 02 04 78 56 34 12
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h78);
    send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    chk("wr_en",   {31'd0, opWrEnable}, 32'd1);
    chk("wr_addr", {24'd0, opAddress},  32'h04);
    chk("wr_data", opWrData,            32'h12345678);
    chk("wr_txv0", {31'd0, opTxValid},  32'd0);
    wait_cyc(1);
    chk("wr_en_off", {31'd0, opWrEnable}, 32'd0);
    chk("wr_txv1",   {31'd0, opTxValid},  32'd1);
    check_tx(1, 32'h000000A5, -1, 0, "wr_ack");
    chk("wr_pulses", wr_cnt, 1);
    chk("wr_err", {24'd0, opErrCount}, 32'd0);

    // read 01 03: opTxValid rises 3 cycles after the ADDR strobe
    send_byte(8'h01); send_byte(8'h03);
    chk("rd_addr", {24'd0, opAddress}, 32'h03);
    chk("rd_lat1", {31'd0, opTxValid}, 32'd0);
    wait_cyc(1);
    chk("rd_lat2", {31'd0, opTxValid}, 32'd0);
    wait_cyc(1);
    chk("rd_lat3", {31'd0, opTxValid}, 32'd1);
    check_tx(4, 32'hDEADBEEF, -1, 0, "rd");
    chk("rd_no_wr", wr_cnt, 1);
    chk("rd_err", {24'd0, opErrCount}, 32'd0);

    // read with ready low for 5 cycles at byte 2
    send_byte(8'h01); send_byte(8'h03);
    wait_cyc(2);
    check_tx(4, 32'hDEADBEEF, 2, 5, "bp");

    // timeout after 02 04 78
    tx_before = tx_cyc;
    send_byte(8'h02); send_byte(8'h04); send_byte(8'h78);
    wait_cyc(TMO - 1);
    chk("tmo_before", {24'd0, opErrCount}, 32'd0);
    wait_cyc(1);
    chk("tmo_err", {24'd0, opErrCount}, 32'd1);
    wait_cyc(3);
    chk("tmo_no_wr", wr_cnt, 1);
    chk("tmo_no_tx", tx_cyc, tx_before);
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    chk("tmo_next_en",   {31'd0, opWrEnable}, 32'd1);
    chk("tmo_next_addr", {24'd0, opAddress},  32'h05);
    chk("tmo_next_data", opWrData,            32'h44332211);
    wait_cyc(1);
    check_tx(1, 32'h000000A5, -1, 0, "tmo_next_ack");

    // a byte landing exactly on the timeout cycle wins
    send_byte(8'h02);
    wait_cyc(TMO - 1); send_byte(8'h06);
    wait_cyc(TMO - 1); send_byte(8'hAA);
    wait_cyc(TMO - 1); send_byte(8'hBB);
    wait_cyc(TMO - 1); send_byte(8'hCC);
    wait_cyc(TMO - 1); send_byte(8'hDD);
    chk("tie_en",   {31'd0, opWrEnable}, 32'd1);
    chk("tie_addr", {24'd0, opAddress},  32'h06);
    chk("tie_data", opWrData,            32'hDDCCBBAA);
    wait_cyc(1);
    check_tx(1, 32'h000000A5, -1, 0, "tie_ack");
    chk("tie_err", {24'd0, opErrCount}, 32'd1);
    chk("tie_pulses", wr_cnt, 3);

    // bad byte in IDLE, then a byte injected during TX_SEND
    send_byte(8'h7F);
    chk("err_idle", {24'd0, opErrCount}, 32'd2);
    send_byte(8'h01); send_byte(8'h03);
    wait_cyc(2);
    fork
      check_tx(4, 32'hDEADBEEF, -1, 0, "inj_tx");
      begin
        wait_cyc(1);
        send_byte(8'h55);
      end
    join
    chk("err_tx", {24'd0, opErrCount}, 32'd3);

    // byte injected during RD_WAIT
    send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h66);
    wait_cyc(1);
    check_tx(4, 32'hDEADBEEF, -1, 0, "inj_rdw");
    chk("err_rdw", {24'd0, opErrCount}, 32'd4);

    // reset in the middle of a write packet
    send_byte(8'h02); send_byte(8'h07); send_byte(8'h01); send_byte(8'h02);
    ipReset = 1'b1;
    wait_cyc(1);
    chk_reset_vals("rst_wr");
    ipReset = 1'b0;
    wait_cyc(8);
    chk("rst_wr_none", wr_cnt, 3);

    // reset during TX_SEND byte 1
    send_byte(8'h01); send_byte(8'h03);
    wait_cyc(2);
    chk("rst_tx_b0", {24'd0, opTxData}, 32'hEF);
    wait_cyc(1);
    chk("rst_tx_b1", {24'd0, opTxData}, 32'hBE);
    ipReset = 1'b1;
    wait_cyc(1);
    chk_reset_vals("rst_tx");
    ipReset = 1'b0;
    wait_cyc(1);
    chk("rst_tx_quiet", {31'd0, opTxValid}, 32'd0);
    send_byte(8'h01); send_byte(8'h03);
    chk("post_rst_lat1", {31'd0, opTxValid}, 32'd0);
    wait_cyc(2);
    chk("post_rst_lat3", {31'd0, opTxValid}, 32'd1);
    check_tx(4, 32'hDEADBEEF, -1, 0, "post_rst");

    // saturation: 300 bad bytes
    for (int i = 0; i < 254; i++) send_byte(8'h7F);
    chk("sat_254", {24'd0, opErrCount}, 32'd254);
    send_byte(8'h7F);
    chk("sat_255", {24'd0, opErrCount}, 32'd255);
    for (int i = 0; i < 45; i++) send_byte(8'h7F);
    chk("sat_hold", {24'd0, opErrCount}, 32'd255);
    chk("final_pulses", wr_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_bridge.md
REG_BUS_BRIDGE -- requirements
Module: reg_bus_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000, giving the inter-byte timeout in ipClk cycles; legal range 2..2^20.
REQ-002 SHALL have ports in this order:
- ipClk  input  1  system clock; all logic on its rising edge.
- ipReset  input  1  synchronous, active-high reset.
- ipRxData  input  8  received UART byte.
- ipRxValid  input  1  single-cycle strobe; ipRxData is valid in that cycle; there is no backpressure.
- opTxData  output  8  byte to UART transmitter.
- opTxValid  output  1  opTxData valid.
- ipTxReady  input  1  transmitter accepts the byte; a transfer occurs when opTxValid and ipTxReady are both high.
- opAddress  output  8  register address to the register block.
- opWrData  output  32  register write data.
- opWrEnable  output  1  single-cycle register write strobe.
- ipRdData  input  32  register read data; valid one cycle after opAddress changes.
- opErrCount  output  8  saturating protocol-error count.

Function
REQ-003 SHALL accept a write packet 0x02, ADDR, D0, D1, D2, D3, where the data word is {D3,D2,D1,D0} (LSB byte first).
REQ-004 SHALL accept a read packet 0x01, ADDR.
REQ-005 SHALL implement the following states:
- IDLE
- CMD_ADDR: expecting the address byte.
- WR_DATA: 2-bit byte index, 0..3.
- WR_STROBE
- RD_WAIT: 2-cycle counter.
- TX_SEND: 2-bit byte index, or 1 byte for an ack.
REQ-006 In IDLE, an rx byte of 0x01 or 0x02 SHALL latch the command and move to CMD_ADDR; any other rx byte SHALL be discarded and SHALL increment opErrCount.
REQ-007 In CMD_ADDR, an rx byte SHALL be loaded into opAddress.
- Write command: go to WR_DATA with index 0.
- Read command: go to RD_WAIT.
REQ-008 In WR_DATA, each rx byte SHALL be stored into opWrData byte lane [index].
- After index 3, go to WR_STROBE.
REQ-009 In WR_STROBE, opWrEnable SHALL be high for exactly one cycle, with opAddress and opWrData stable. The next state is TX_SEND with the single ack byte 0xA5.
REQ-010 RD_WAIT SHALL last exactly 2 cycles after opAddress is loaded. On its final cycle, ipRdData SHALL be captured into an internal 32-bit shift register; then go to TX_SEND with 4 bytes.
REQ-011 TX_SEND behaviour:
- SHALL present bytes LSB first: rd[7:0], rd[15:8], rd[23:16], rd[31:24].
- opTxValid SHALL rise in the first TX_SEND cycle.
- After each transfer, the next byte SHALL be presented in the following cycle with opTxValid held high, giving back-to-back transfers.
- opTxValid SHALL drop in the cycle after the last transfer, and the state SHALL return to IDLE.
REQ-012 While opTxValid is high and ipTxReady is low, opTxData SHALL hold its value.
REQ-013 Inter-byte timeout:
- In CMD_ADDR and WR_DATA, a counter SHALL count cycles since the last accepted byte.
- On reaching TIMEOUT: return to IDLE, increment opErrCount, assert no opWrEnable, send no response.
- If an rx byte arrives in the same cycle as the timeout, the byte wins: it is accepted and the counter clears.
REQ-014 Any rx byte arriving in WR_STROBE, RD_WAIT or TX_SEND SHALL be dropped and SHALL increment opErrCount.
REQ-015 opErrCount SHALL saturate at 255. Multiple error sources in one cycle SHALL count as a single increment.
REQ-016 opAddress and opWrData SHALL hold their last values outside packet reception.
REQ-017 opWrEnable SHALL never assert for a read packet or for an incomplete write packet.
REQ-018 Total latency:
- Write: the last data byte strobe is at cycle N, opWrEnable at N+1, opTxValid at N+2.
- Read: the ADDR strobe is at cycle N, opTxValid at N+3.

Reset
REQ-019 While ipReset is high at a clock edge, the block SHALL:
- enter IDLE;
- set opTxValid=0, opTxData=0x00, opWrEnable=0, opAddress=0x00, opWrData=0, opErrCount=0;
- clear all counters and indices.
REQ-020 Reset asserted mid-packet or mid-transmit SHALL abort the transaction.
- opTxValid SHALL drop in the cycle after the reset edge.
- No partial write SHALL occur.
REQ-021 rx strobes during reset SHALL be ignored.

Verification
REQ-022 Write: rx 02 04 78 56 34 12 -> exactly one opWrEnable pulse with opAddress=0x04 and opWrData=0x12345678, then tx 0xA5, opErrCount=0.
REQ-023 Read: rx 01 03 with ipRdData=0xDEADBEEF -> opAddress=0x03, then tx EF BE AD DE, opTxValid first high 3 cycles after the ADDR strobe.
REQ-024 Backpressure: read, with ipTxReady low for 5 cycles at byte 2 -> opTxData held at 0xAD throughout; byte order and count unchanged.
REQ-025 Timeout: rx 02 04 78 then no rx for TIMEOUT cycles -> IDLE, opErrCount=1, no opWrEnable, no tx; a subsequent valid packet works normally.
REQ-026 Errors: rx 0x7F in IDLE, plus a byte injected during TX_SEND -> opErrCount=2, tx stream unaffected; 300 bad bytes -> opErrCount=255.
REQ-027 Reset: ipReset pulsed during TX_SEND byte 1 -> opTxValid low the next cycle, all outputs at reset values, next packet correct.
